// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Owns the program counter, drives the word-addressed instruction memory
//   and registers one fetched instruction into the IF/ID stage toward decode.
//   Handles branch/jump redirects, decode backpressure, out-of-range PC
//   faults and a run/hold control.
//
// Ports
//   clk, reset_n                 clock, async active-low reset
//   run                          1 = fetch allowed, 0 = hold
//   imem_addr                    memory address (the pc register itself)
//   imem_instr, imem_next_pc     combinational memory read data and addr+1
//   redirect_valid, redirect_pc  taken branch/jump and its target
//   if_valid, if_ready           IF/ID stage handshake toward decode
//   if_instr, if_pc              registered instruction and its address
//   fault                        sticky: pc went above IMEM_LAST
//   fetch_count                  instructions accepted by decode (wraps)
module fetch_sequencer #(
    parameter int unsigned     PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter logic [PC_W-1:0] IMEM_LAST = PC_W'(2048)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            run,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_instr,
    input  logic [PC_W-1:0] imem_next_pc,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_instr,
    output logic [PC_W-1:0] if_pc,
    output logic            fault,
    output logic [31:0]     fetch_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            vld_d;
    logic [31:0]     instr_d;
    logic [PC_W-1:0] ifpc_d;
    logic            fault_d;
    logic            adv;

    // The output stage can take a new value when it is empty or being drained.
    assign adv       = !if_valid || if_ready;
    assign imem_addr = pc_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
            fault    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            if_valid <= vld_d;
            if_instr <= instr_d;
            if_pc    <= ifpc_d;
            fault    <= fault_d;
        end
    end

    // Counts every accept, including one that a same-cycle redirect squashes:
    // decode already took that instruction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            fetch_count <= '0;
        else if (if_valid && if_ready)
            fetch_count <= fetch_count + 32'd1;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        vld_d   = if_valid;
        instr_d = if_instr;
        ifpc_d  = if_pc;
        fault_d = fault;
        unique case (state_q)
            IDLE: begin
                vld_d = 1'b0;
                if (redirect_valid) pc_d = redirect_pc;
                if (run) state_d = RUN;
            end
            RUN: begin
                if (redirect_valid) begin
                    // Squash whatever is held; target appears one edge later.
                    pc_d  = redirect_pc;
                    vld_d = 1'b0;
                end else if (pc_q > IMEM_LAST && adv) begin
                    fault_d = 1'b1;
                    vld_d   = 1'b0;
                    state_d = FAULT;
                end else if (!run && adv) begin
                    // pc is left alone so fetching resumes at the same word.
                    vld_d   = 1'b0;
                    state_d = IDLE;
                end else if (adv) begin
                    instr_d = imem_instr;
                    ifpc_d  = pc_q;
                    vld_d   = 1'b1;
                    pc_d    = imem_next_pc;
                end
            end
            FAULT: begin
                vld_d   = 1'b0;
                fault_d = 1'b1;
                // Only an in-range target clears the fault.
                if (redirect_valid && redirect_pc <= IMEM_LAST) begin
                    pc_d    = redirect_pc;
                    fault_d = 1'b0;
                    state_d = RUN;
                end
            end
            default: begin
                vld_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        run;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] imem_next_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        fault;
    logic [31:0] fetch_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ (a * 32'h0001_0003);
    endfunction

    // Combinational instruction memory model.
    assign imem_instr   = word(imem_addr);
    assign imem_next_pc = imem_addr + 32'd1;

    fetch_sequencer #(.PC_W(32), .RESET_PC(32'd0), .IMEM_LAST(32'd2048)) dut (
        .clk(clk), .reset_n(reset_n), .run(run),
        .imem_addr(imem_addr), .imem_instr(imem_instr), .imem_next_pc(imem_next_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .fault(fault), .fetch_count(fetch_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; run = 1'b1; if_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0;
        step();
        n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %0b want 0", if_valid); end
        n_cmp++; if (imem_addr !== 32'd0) begin n_bad++; $display("FAIL rst_addr: got %0d want 0", imem_addr); end
        n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL rst_fault: got %0b want 0", fault); end
        n_cmp++; if (fetch_count !== 32'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", fetch_count); end
        n_cmp++; if (if_instr !== 32'd0 || if_pc !== 32'd0) begin n_bad++; $display("FAIL rst_stage: got instr %0h pc %0d want 0 0", if_instr, if_pc); end
        reset_n = 1'b1;
        step(); // IDLE -> RUN
        n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL first_edge_valid: got %0b want 0", if_valid); end
        for (int i = 0; i < 6; i++) begin
            step();
            n_cmp++;
            if (if_valid !== 1'b1 || if_pc !== 32'(i) || if_instr !== word(32'(i)) || fetch_count !== 32'(i)) begin
                n_bad++;
                $display("FAIL seq_%0d: got v=%0b pc=%0d instr=%0h cnt=%0d want v=1 pc=%0d instr=%0h cnt=%0d",
                         i, if_valid, if_pc, if_instr, fetch_count, i, word(32'(i)), i);
            end
        end
        step();
        n_cmp++; if (fetch_count !== 32'd6 || if_pc !== 32'd6) begin n_bad++; $display("FAIL seq_count: got cnt=%0d pc=%0d want 6 6", fetch_count, if_pc); end
    endtask

    task automatic test_backpressure();
        do_reset();
        run = 1'b1; if_ready = 1'b1;
        step(); // IDLE -> RUN
        step(); // if_pc 0
        step(); // if_pc 1
        step(); // if_pc 2
        n_cmp++; if (if_pc !== 32'd2 || imem_addr !== 32'd3) begin n_bad++; $display("FAIL bp_setup: got pc=%0d addr=%0d want 2 3", if_pc, imem_addr); end
        if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (if_valid !== 1'b1 || if_pc !== 32'd2 || if_instr !== word(32'd2) || imem_addr !== 32'd3 || fetch_count !== 32'd2) begin
                n_bad++;
                $display("FAIL bp_hold_%0d: got v=%0b pc=%0d instr=%0h addr=%0d cnt=%0d want v=1 pc=2 instr=%0h addr=3 cnt=2",
                         i, if_valid, if_pc, if_instr, imem_addr, fetch_count, word(32'd2));
            end
        end
        if_ready = 1'b1;
        step();
        n_cmp++; if (if_pc !== 32'd3 || if_valid !== 1'b1 || fetch_count !== 32'd3) begin n_bad++; $display("FAIL bp_release: got pc=%0d v=%0b cnt=%0d want 3 1 3", if_pc, if_valid, fetch_count); end
    endtask

    task automatic test_redirect_stall();
        step(); // if_pc 4, 4 accepted so far
        n_cmp++; if (if_pc !== 32'd4 || fetch_count !== 32'd4) begin n_bad++; $display("FAIL rd_setup: got pc=%0d cnt=%0d want 4 4", if_pc, fetch_count); end
        if_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'd1;
        step();
        n_cmp++; if (if_valid !== 1'b0 || imem_addr !== 32'd1 || fetch_count !== 32'd4) begin n_bad++; $display("FAIL rd_squash: got v=%0b addr=%0d cnt=%0d want 0 1 4", if_valid, imem_addr, fetch_count); end
        redirect_valid = 1'b0; if_ready = 1'b1;
        step();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'd1 || if_instr !== word(32'd1) || fetch_count !== 32'd4) begin n_bad++; $display("FAIL rd_target: got v=%0b pc=%0d instr=%0h cnt=%0d want 1 1 %0h 4", if_valid, if_pc, if_instr, fetch_count, word(32'd1)); end
    endtask

    task automatic test_fault();
        redirect_valid = 1'b1; redirect_pc = 32'd2047;
        step();
        n_cmp++; if (if_valid !== 1'b0 || imem_addr !== 32'd2047) begin n_bad++; $display("FAIL ft_redirect: got v=%0b addr=%0d want 0 2047", if_valid, imem_addr); end
        redirect_valid = 1'b0;
        step();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'd2047) begin n_bad++; $display("FAIL ft_2047: got v=%0b pc=%0d want 1 2047", if_valid, if_pc); end
        step();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'd2048 || fault !== 1'b0) begin n_bad++; $display("FAIL ft_2048: got v=%0b pc=%0d fault=%0b want 1 2048 0", if_valid, if_pc, fault); end
        step();
        n_cmp++; if (fault !== 1'b1 || if_valid !== 1'b0 || imem_addr !== 32'd2049) begin n_bad++; $display("FAIL ft_enter: got fault=%0b v=%0b addr=%0d want 1 0 2049", fault, if_valid, imem_addr); end
        step();
        n_cmp++; if (fault !== 1'b1 || if_valid !== 1'b0 || imem_addr !== 32'd2049) begin n_bad++; $display("FAIL ft_sticky: got fault=%0b v=%0b addr=%0d want 1 0 2049", fault, if_valid, imem_addr); end
        redirect_valid = 1'b1; redirect_pc = 32'd5000;
        step();
        n_cmp++; if (fault !== 1'b1 || if_valid !== 1'b0 || imem_addr !== 32'd2049) begin n_bad++; $display("FAIL ft_bad_target: got fault=%0b v=%0b addr=%0d want 1 0 2049", fault, if_valid, imem_addr); end
        redirect_pc = 32'd3;
        step();
        n_cmp++; if (fault !== 1'b0 || if_valid !== 1'b0 || imem_addr !== 32'd3) begin n_bad++; $display("FAIL ft_exit: got fault=%0b v=%0b addr=%0d want 0 0 3", fault, if_valid, imem_addr); end
        redirect_valid = 1'b0;
        step();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'd3 || if_instr !== word(32'd3)) begin n_bad++; $display("FAIL ft_resume: got v=%0b pc=%0d instr=%0h want 1 3 %0h", if_valid, if_pc, if_instr, word(32'd3)); end
    endtask

    task automatic test_run_drop();
        run = 1'b0;
        step();
        n_cmp++; if (if_valid !== 1'b0 || imem_addr !== 32'd4) begin n_bad++; $display("FAIL rn_drop: got v=%0b addr=%0d want 0 4", if_valid, imem_addr); end
        step();
        n_cmp++; if (if_valid !== 1'b0 || imem_addr !== 32'd4) begin n_bad++; $display("FAIL rn_hold: got v=%0b addr=%0d want 0 4", if_valid, imem_addr); end
        run = 1'b1;
        step(); // IDLE -> RUN
        n_cmp++; if (if_valid !== 1'b0 || imem_addr !== 32'd4) begin n_bad++; $display("FAIL rn_rearm: got v=%0b addr=%0d want 0 4", if_valid, imem_addr); end
        step();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'd4 || imem_addr !== 32'd5) begin n_bad++; $display("FAIL rn_resume: got v=%0b pc=%0d addr=%0d want 1 4 5", if_valid, if_pc, imem_addr); end
    endtask

    task automatic test_idle_redirect();
        do_reset();
        run = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'd7;
        step();
        n_cmp++; if (if_valid !== 1'b0 || imem_addr !== 32'd7) begin n_bad++; $display("FAIL idle_redirect: got v=%0b addr=%0d want 0 7", if_valid, imem_addr); end
        redirect_valid = 1'b0; run = 1'b1;
        step(); // IDLE -> RUN
        step();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'd7 || if_instr !== word(32'd7)) begin n_bad++; $display("FAIL idle_target: got v=%0b pc=%0d instr=%0h want 1 7 %0h", if_valid, if_pc, if_instr, word(32'd7)); end
    endtask

    task automatic test_async_reset();
        step();
        step();
        n_cmp++; if (if_valid !== 1'b1 || fetch_count === 32'd0) begin n_bad++; $display("FAIL ar_setup: got v=%0b cnt=%0d want 1 nonzero", if_valid, fetch_count); end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (if_valid !== 1'b0 || fault !== 1'b0 || fetch_count !== 32'd0 || imem_addr !== 32'd0) begin n_bad++; $display("FAIL ar_midrun: got v=%0b fault=%0b cnt=%0d addr=%0d want 0 0 0 0", if_valid, fault, fetch_count, imem_addr); end
        step();
        reset_n = 1'b1;
        // Drive into FAULT, then reset between edges.
        step(); // IDLE -> RUN
        redirect_valid = 1'b1; redirect_pc = 32'd3000;
        step();
        redirect_valid = 1'b0;
        step();
        n_cmp++; if (fault !== 1'b1) begin n_bad++; $display("FAIL ar_fault_setup: got fault=%0b want 1", fault); end
        #3 reset_n = 1'b0;
        #1;
        n_cmp++; if (fault !== 1'b0 || if_valid !== 1'b0 || imem_addr !== 32'd0) begin n_bad++; $display("FAIL ar_fault: got fault=%0b v=%0b addr=%0d want 0 0 0", fault, if_valid, imem_addr); end
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_redirect_stall();
        test_fault();
        test_run_drop();
        test_idle_redirect();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
